// File: rtl/bios_code_loader.sv
// BIOS code loader: copies NUM_WORDS hardcoded BIOS words into the code memory via a valid/ready write port.
// Optional BIOS_CODE_LOADER_CHECKSUM_EN adds a transfer checksum that blocks CPU release on mismatch.
module bios_code_loader #(
    parameter int NUM_WORDS  = 16,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 5,
    parameter int BASE_ADDR  = 16,
    parameter int AUTO_START = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_WORDS*DATA_W-1:0] bios_words,
    input  logic                        wr_ready,
    output logic                        wr_valid,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    output logic                        cpu_hold,
    output logic                        busy,
    output logic                        done
`ifdef BIOS_CODE_LOADER_CHECKSUM_EN
    ,
    input  logic [DATA_W-1:0]           expected_sum,
    output logic [DATA_W-1:0]           checksum,
    output logic                        sum_err
`endif
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r, next_state_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic                wr_valid_s, cpu_hold_s, busy_s, done_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic                launch_s, xfer_s, last_s;
`ifdef BIOS_CODE_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   checksum_s;
    logic                sum_err_s;
`endif

    function automatic logic [DATA_W-1:0] word_at(input logic [NUM_WORDS*DATA_W-1:0] words,
                                                  input logic [IDX_W-1:0] k);
        word_at = words[int'(k)*DATA_W +: DATA_W];
    endfunction

    // Address wraps modulo 2^ADDR_W by truncation of the sum.
    function automatic logic [ADDR_W-1:0] addr_at(input logic [IDX_W-1:0] k);
        addr_at = BASE + ADDR_W'(k);
    endfunction

    // Launch and transfer qualifiers shared by next-state and output logic.
    always_comb begin
        launch_s = 1'b0;
        case (state_r)
            IDLE:    launch_s = (AUTO_START != 0) || start;
            DONE:    launch_s = start;
            default: launch_s = 1'b0;
        endcase
        xfer_s = (state_r == LOAD) && wr_valid && wr_ready;
        last_s = (idx_r == LAST_IDX);
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= {IDX_W{1'b0}};
            wr_valid <= 1'b0;
            wr_addr  <= {ADDR_W{1'b0}};
            wr_data  <= {DATA_W{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
`ifdef BIOS_CODE_LOADER_CHECKSUM_EN
            checksum <= {DATA_W{1'b0}};
            sum_err  <= 1'b0;
`endif
        end else begin
            state_r  <= next_state_s;
            idx_r    <= idx_s;
            wr_valid <= wr_valid_s;
            wr_addr  <= wr_addr_s;
            wr_data  <= wr_data_s;
            busy     <= busy_s;
            done     <= done_s;
            cpu_hold <= cpu_hold_s;
`ifdef BIOS_CODE_LOADER_CHECKSUM_EN
            checksum <= checksum_s;
            sum_err  <= sum_err_s;
`endif
        end
    end

    // Next-state logic; start during LOAD is deliberately ignored.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = launch_s ? LOAD : IDLE;
            LOAD:    next_state_s = (xfer_s && last_s) ? DONE : LOAD;
            DONE:    next_state_s = launch_s ? LOAD : DONE;
            default: next_state_s = IDLE;
        endcase
    end

    // Next values for the registered outputs; hold everything unless launching or transferring.
    always_comb begin
        idx_s      = idx_r;
        wr_valid_s = wr_valid;
        wr_addr_s  = wr_addr;
        wr_data_s  = wr_data;
        busy_s     = busy;
        done_s     = done;
        cpu_hold_s = cpu_hold;
`ifdef BIOS_CODE_LOADER_CHECKSUM_EN
        checksum_s = checksum;
        sum_err_s  = sum_err;
`endif
        if (launch_s) begin
            idx_s      = {IDX_W{1'b0}};
            wr_valid_s = 1'b1;
            wr_addr_s  = BASE;
            wr_data_s  = word_at(bios_words, {IDX_W{1'b0}});
            busy_s     = 1'b1;
            done_s     = 1'b0;
            cpu_hold_s = 1'b1;
`ifdef BIOS_CODE_LOADER_CHECKSUM_EN
            checksum_s = {DATA_W{1'b0}};
            sum_err_s  = 1'b0;
`endif
        end else if (xfer_s) begin
`ifdef BIOS_CODE_LOADER_CHECKSUM_EN
            checksum_s = checksum + wr_data;
`endif
            if (last_s) begin
                wr_valid_s = 1'b0;
                busy_s     = 1'b0;
                done_s     = 1'b1;
`ifdef BIOS_CODE_LOADER_CHECKSUM_EN
                sum_err_s  = (checksum_s != expected_sum);
                cpu_hold_s = sum_err_s;
`else
                cpu_hold_s = 1'b0;
`endif
            end else begin
                idx_s      = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                wr_addr_s  = addr_at(idx_s);
                wr_data_s  = word_at(bios_words, idx_s);
            end
        end else begin
            idx_s = idx_r;
        end
    end

endmodule

// File: doc/bios_code_loader.md
Name: bios_code_loader

Overview:
- Sequential copier that reads the 16 hardcoded BIOS instruction words and writes them, one per handshake, into the i281 code memory's high BIOS region.
- Holds the CPU (cpu_hold) while the copy is in progress and releases it when the copy completes.
- Sits between the BIOS ROM outputs and the code-memory write port.
- Gives the code memory a single write path for both the boot copy and later user-initiated reloads.

Parameters:
- NUM_WORDS, 16, number of BIOS words copied; legal range 1..16.
- DATA_W, 16, instruction word width.
- ADDR_W, 5, code-memory address width (32 words).
- BASE_ADDR, 16, code-memory address that receives BIOS word 0.
- AUTO_START, 1, when 1 a copy begins automatically after reset release.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to (re)load; sampled in IDLE or DONE only.
- bios_words  input  NUM_WORDS*DATA_W  flattened BIOS words; word k occupies bits [k*DATA_W +: DATA_W].
- wr_ready  input  1  code memory accepts the current word this cycle.
- wr_valid  output  1  write request to code memory.
- wr_addr  output  ADDR_W  code-memory write address.
- wr_data  output  DATA_W  code-memory write data.
- cpu_hold  output  1  stall the CPU fetch/PC while high.
- busy  output  1  copy in progress.
- done  output  1  copy finished; held until the next start or Reset.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, active-high): state=IDLE, idx=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, cpu_hold=1.
- States: IDLE, LOAD, DONE.
- IDLE:
  - If AUTO_START=1, go to LOAD on the first clock after Reset deasserts.
  - If AUTO_START=0, go to LOAD on start=1; otherwise remain in IDLE with cpu_hold=1.
- Entering LOAD (registered on the transition edge): idx=0, wr_valid=1, wr_addr=BASE_ADDR, wr_data=word 0, busy=1, done=0, cpu_hold=1.
- LOAD handshake:
  - wr_addr and wr_data stay stable while wr_valid=1 and wr_ready=0; stalls of any length are allowed.
  - A transfer occurs on the edge where wr_valid=1 and wr_ready=1.
  - After a transfer of idx<NUM_WORDS-1: idx increments; the next cycle presents word idx+1 at BASE_ADDR+idx+1. There are no bubbles, so 1 word/cycle when wr_ready is held high.
  - After the transfer of idx=NUM_WORDS-1: wr_valid=0, busy=0, done=1, cpu_hold=0; go to DONE.
  - Back-to-back throughput: NUM_WORDS cycles from the first wr_valid to the last transfer; done rises on the following cycle.
- wr_addr = (BASE_ADDR + idx) truncated to ADDR_W bits. This wraps modulo 2^ADDR_W; no error is raised.
- bios_words is sampled at the moment each word is presented, not latched at start.
- start while in LOAD is ignored; the copy continues unchanged.
- DONE: start=1 re-enters LOAD at word 0 (done drops, cpu_hold rises on the same edge).
- Reset asserted mid-copy: immediately return to IDLE with reset values. The partially written region is left as is. With AUTO_START=1 the copy restarts from word 0.
- wr_ready while wr_valid=0 has no effect.

Optional Feature:
BIOS_CODE_LOADER_CHECKSUM_EN
- Defined:
  - Adds input expected_sum [DATA_W-1:0] and outputs checksum [DATA_W-1:0] and sum_err [1].
  - checksum resets to 0 and clears on entry to LOAD.
  - On each transfer, checksum accumulates wr_data modulo 2^DATA_W.
  - On entry to DONE, sum_err = (checksum_final != expected_sum). Entering DONE and updating sum_err happen on the same edge.
  - sum_err=1 keeps cpu_hold=1 in DONE; done still asserts.
  - sum_err clears on Reset or on re-entry to LOAD.
- Not defined: the ports above do not exist, and DONE always releases cpu_hold.

Test Plan:
- Auto boot, wr_ready=1, word0=16'h1120, word1=16'h5001, word2=16'hE0FB -> cycle 1 after reset: wr_addr=16, wr_data=16'h1120. Cycle 2: addr 17, 16'h5001. Cycle 3: addr 18, 16'hE0FB. After 16 transfers: done=1, cpu_hold=0, wr_valid=0.
- wr_ready held low 5 cycles on word 3 -> wr_valid=1, wr_addr=19 and wr_data stable for all 5 cycles; exactly one transfer of word 3 when ready rises; total 16 transfers.
- Reset pulsed after 7 transfers -> outputs immediately at reset values; after release the copy restarts at addr 16 with word 0; 16 further transfers.
- AUTO_START=0: no start -> IDLE, cpu_hold=1, wr_valid=0 for 20 cycles. start pulse -> copy runs. start pulsed during LOAD -> ignored, exactly 16 transfers. start in DONE -> reload from addr 16.
- BASE_ADDR=24, NUM_WORDS=16 -> addresses 24..31 then 0..7, verifying the modulo-32 wrap.
- CHECKSUM_EN, all words 16'h0001: expected_sum=16'h0010 -> checksum=16'h0010, sum_err=0, cpu_hold=0. expected_sum=16'h0011 -> sum_err=1, cpu_hold stays 1, done=1.
